// File: rtl/ram1_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ram1_responder_pkg
// Brief    : Shared constants and FSM state encoding for the RAM1 responder.
// Revision : 1.0 - initial release
// ============================================================================
package ram1_responder_pkg;

    localparam int c_ADDR_W = 18;
    localparam int c_DATA_W = 16;
    localparam int c_LAT_W  = 3;
    localparam int c_CNT_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WRITE    = 2'd1,
        ST_RD_WAIT  = 2'd2,
        ST_RD_DRIVE = 2'd3
    } state_e;

endpackage : ram1_responder_pkg
`default_nettype wire

// File: rtl/ram1_resp_mem.sv
`default_nettype none
// ============================================================================
// Module   : ram1_resp_mem
// Brief    : 2^DEPTH_W x DATA_W word array, synchronous write, async read.
// Revision : 1.0 - initial release
// ============================================================================
module ram1_resp_mem #(
    parameter int DEPTH_W = 10,
    parameter int DATA_W  = 16
) (
    input  logic               clk,
    input  logic               i_we,
    input  logic [DEPTH_W-1:0] i_waddr,
    input  logic [DATA_W-1:0]  i_wdata,
    input  logic [DEPTH_W-1:0] i_raddr,
    output logic [DATA_W-1:0]  o_rdata
);

    logic [DATA_W-1:0] r_mem_q [0:(1<<DEPTH_W)-1];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem_q[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem_q[i_raddr];

endmodule : ram1_resp_mem
`default_nettype wire

// File: rtl/ram1_responder.sv
`default_nettype none
// ============================================================================
// Module   : ram1_responder
// Brief    : Device-side RAM1 SRAM emulator with configurable read latency.
// Revision : 1.0 - initial release
// ============================================================================
module ram1_responder
    import ram1_responder_pkg::*;
#(
    parameter int ADDR_W   = c_ADDR_W,
    parameter int DATA_W   = c_DATA_W,
    parameter int DEPTH_W  = 10,
    parameter int READ_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_data_i,
    input  logic              ram_oe_n,
    input  logic              ram_we_n,
    output logic [DATA_W-1:0] ram_data_o,
    output logic              ram_data_oe,
    output logic              err_conflict,
    output logic [15:0]       wr_count,
    output logic [15:0]       rd_count
);

    localparam logic [c_LAT_W-1:0] c_LAT_LOAD = c_LAT_W'(READ_LAT - 1);

    // Input sample stage plus previous-sample copies for edge/change detect
    logic [ADDR_W-1:0]  r_addr_s_q;
    logic [ADDR_W-1:0]  r_addr_p_q;
    logic [DATA_W-1:0]  r_data_s_q;
    logic               r_oe_n_s_q;
    logic               r_oe_n_p_q;
    logic               r_we_n_s_q;
    logic               r_we_n_p_q;

    state_e             r_state_q,    w_state_d;
    logic [c_LAT_W-1:0] r_cnt_q,      w_cnt_d;
    logic [DATA_W-1:0]  r_dout_q,     w_dout_d;
    logic               r_doe_q,      w_doe_d;
    logic               r_err_q,      w_err_d;
    logic [c_CNT_W-1:0] r_wr_cnt_q,   w_wr_cnt_d;
    logic [c_CNT_W-1:0] r_rd_cnt_q,   w_rd_cnt_d;
    logic [DEPTH_W-1:0] r_cap_addr_q, w_cap_addr_d;
    logic [DATA_W-1:0]  r_cap_data_q, w_cap_data_d;

    logic               w_commit;
    logic               w_we_rise;
    logic               w_oe_rise;
    logic               w_addr_chg;
    logic [DATA_W-1:0]  w_mem_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr_s_q <= '0;
            r_addr_p_q <= '0;
            r_data_s_q <= '0;
            r_oe_n_s_q <= 1'b1;
            r_oe_n_p_q <= 1'b1;
            r_we_n_s_q <= 1'b1;
            r_we_n_p_q <= 1'b1;
        end else begin
            r_addr_s_q <= ram_addr;
            r_addr_p_q <= r_addr_s_q;
            r_data_s_q <= ram_data_i;
            r_oe_n_s_q <= ram_oe_n;
            r_oe_n_p_q <= r_oe_n_s_q;
            r_we_n_s_q <= ram_we_n;
            r_we_n_p_q <= r_we_n_s_q;
        end
    end

    assign w_we_rise  = r_we_n_s_q & ~r_we_n_p_q;
    assign w_oe_rise  = r_oe_n_s_q & ~r_oe_n_p_q;
    assign w_addr_chg = (r_addr_s_q != r_addr_p_q);

    ram1_resp_mem #(
        .DEPTH_W (DEPTH_W),
        .DATA_W  (DATA_W)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_commit),
        .i_waddr (r_cap_addr_q),
        .i_wdata (r_cap_data_q),
        .i_raddr (r_addr_s_q[DEPTH_W-1:0]),
        .o_rdata (w_mem_rdata)
    );

    always_comb begin
        w_state_d    = r_state_q;
        w_cnt_d      = r_cnt_q;
        w_dout_d     = r_dout_q;
        w_doe_d      = r_doe_q;
        w_err_d      = r_err_q | (~r_oe_n_s_q & ~r_we_n_s_q);
        w_wr_cnt_d   = r_wr_cnt_q;
        w_rd_cnt_d   = r_rd_cnt_q;
        w_cap_addr_d = r_cap_addr_q;
        w_cap_data_d = r_cap_data_q;
        w_commit     = 1'b0;

        // Capture tracks the bus for the whole low phase of we_n; last value wins
        if (!r_we_n_s_q) begin
            w_cap_addr_d = r_addr_s_q[DEPTH_W-1:0];
            w_cap_data_d = r_data_s_q;
        end

        case (r_state_q)
            ST_IDLE: begin
                if (!r_we_n_s_q) begin
                    w_state_d = ST_WRITE;
                end else if (!r_oe_n_s_q) begin
                    w_state_d = ST_RD_WAIT;
                    w_cnt_d   = c_LAT_LOAD;
                end
            end

            ST_WRITE: begin
                if (w_we_rise) begin
                    w_commit   = 1'b1;
                    w_wr_cnt_d = r_wr_cnt_q + 16'd1;
                    w_state_d  = ST_IDLE;
                end
            end

            ST_RD_WAIT: begin
                if (!r_we_n_s_q) begin
                    w_state_d = ST_WRITE;
                end else if (r_oe_n_s_q) begin
                    w_state_d = ST_IDLE;
                end else if (w_addr_chg) begin
                    // Latency restarts from the most recent address change
                    w_cnt_d = c_LAT_LOAD;
                end else if (r_cnt_q == '0) begin
                    w_state_d = ST_RD_DRIVE;
                    w_dout_d  = w_mem_rdata;
                    w_doe_d   = 1'b1;
                end else begin
                    w_cnt_d = r_cnt_q - 1'b1;
                end
            end

            ST_RD_DRIVE: begin
                if (!r_we_n_s_q) begin
                    w_doe_d   = 1'b0;
                    w_state_d = ST_WRITE;
                end else if (w_oe_rise) begin
                    w_doe_d    = 1'b0;
                    w_rd_cnt_d = r_rd_cnt_q + 16'd1;
                    w_state_d  = ST_IDLE;
                end else if (w_addr_chg) begin
                    w_doe_d   = 1'b0;
                    w_cnt_d   = c_LAT_LOAD;
                    w_state_d = ST_RD_WAIT;
                end
            end

            default: begin
                w_doe_d   = 1'b0;
                w_state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q    <= ST_IDLE;
            r_cnt_q      <= '0;
            r_dout_q     <= '0;
            r_doe_q      <= 1'b0;
            r_err_q      <= 1'b0;
            r_wr_cnt_q   <= '0;
            r_rd_cnt_q   <= '0;
            r_cap_addr_q <= '0;
            r_cap_data_q <= '0;
        end else begin
            r_state_q    <= w_state_d;
            r_cnt_q      <= w_cnt_d;
            r_dout_q     <= w_dout_d;
            r_doe_q      <= w_doe_d;
            r_err_q      <= w_err_d;
            r_wr_cnt_q   <= w_wr_cnt_d;
            r_rd_cnt_q   <= w_rd_cnt_d;
            r_cap_addr_q <= w_cap_addr_d;
            r_cap_data_q <= w_cap_data_d;
        end
    end

    assign ram_data_o   = r_dout_q;
    assign ram_data_oe  = r_doe_q;
    assign err_conflict = r_err_q;
    assign wr_count     = r_wr_cnt_q;
    assign rd_count     = r_rd_cnt_q;

endmodule : ram1_responder
`default_nettype wire
